nn_argmax_detector: RTL and testbench

//  Consumes the ReLU'd score vector of dense_layer_2 (final classifier layer), scans it

---
 rtl/nn_argmax_detector_pkg.sv | 23 ++
 rtl/nn_argmax_detector.sv | 143 ++++++++++++++
 tb/tb_nn_argmax_detector.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_argmax_detector_pkg.sv
// Shared constants and types for the classifier back-end: output layer size,
// detection policy defaults, the signed score type and the detector FSM states.
package nn_argmax_detector_pkg;

    localparam int OUT_SIZE_2 = 4;

    localparam logic signed [7:0] DETECT_THRESHOLD = 8'sd16;
    localparam int                DETECT_AGREE_CNT = 3;

    typedef logic signed [7:0] score_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Strictly-greater compare so that ties keep the lowest index already held.
    function automatic logic beats(input score_t cand, input score_t best);
        return (cand > best);
    endfunction

endpackage

// File: rtl/nn_argmax_detector.sv
// Serial arg-max over the final-layer score vector, followed by a confidence
// threshold and an N-consecutive-agreement filter that raises word_detected.
module nn_argmax_detector
    import nn_argmax_detector_pkg::*;
#(
    parameter int     N_CLASSES = OUT_SIZE_2,
    parameter score_t THRESHOLD = DETECT_THRESHOLD,
    parameter int     AGREE_CNT = DETECT_AGREE_CNT,
    localparam int    IDX_W     = $clog2(N_CLASSES),
    localparam int    CNT_W     = $clog2(AGREE_CNT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  score_t [N_CLASSES-1:0] scores,
    output logic                   class_valid,
    output logic [IDX_W-1:0]       class_idx,
    output score_t                 max_score,
    output logic                   confident,
    output logic                   word_detected,
    output logic [IDX_W-1:0]       detected_class
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(AGREE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                 state_q;
    score_t [N_CLASSES-1:0] vec_q;
    score_t                 best_val_q;
    logic [IDX_W-1:0]       best_idx_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   in_ready_q;
    logic                   class_valid_q;
    logic [IDX_W-1:0]       class_idx_q;
    score_t                 max_score_q;
    logic                   confident_q;
    logic                   word_detected_q;
    logic [IDX_W-1:0]       detected_class_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [IDX_W-1:0]       last_class_q;
    logic [IDX_W-1:0]       last_class_d;
    logic                   conf_s;
    logic                   hit_s;

    // Streak update for the decision retired in DONE; a saturated streak never re-fires.
    always_comb begin
        conf_s       = (best_val_q >= THRESHOLD);
        cnt_d        = cnt_q;
        last_class_d = last_class_q;
        hit_s        = 1'b0;
        if (!conf_s) begin
            cnt_d = '0;
        end else if ((best_idx_q == last_class_q) && (cnt_q != '0)) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                hit_s = ((cnt_q + CNT_ONE) == CNT_MAX);
            end
        end else begin
            cnt_d        = CNT_ONE;
            last_class_d = best_idx_q;
            hit_s        = (CNT_ONE == CNT_MAX);
        end
    end

    // Control FSM, scan datapath and registered decision/detection outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            vec_q            <= '0;
            best_val_q       <= '0;
            best_idx_q       <= '0;
            idx_q            <= '0;
            in_ready_q       <= 1'b1;
            class_valid_q    <= 1'b0;
            class_idx_q      <= '0;
            max_score_q      <= '0;
            confident_q      <= 1'b0;
            word_detected_q  <= 1'b0;
            detected_class_q <= '0;
            cnt_q            <= '0;
            last_class_q     <= '0;
        end else begin
            class_valid_q   <= 1'b0;
            word_detected_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        vec_q      <= scores;
                        best_val_q <= scores[0];
                        best_idx_q <= '0;
                        idx_q      <= IDX_ONE;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (beats(vec_q[idx_q], best_val_q)) begin
                        best_val_q <= vec_q[idx_q];
                        best_idx_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    class_idx_q     <= best_idx_q;
                    max_score_q     <= best_val_q;
                    confident_q     <= conf_s;
                    cnt_q           <= cnt_d;
                    last_class_q    <= last_class_d;
                    class_valid_q   <= 1'b1;
                    word_detected_q <= hit_s;
                    if (hit_s) begin
                        detected_class_q <= best_idx_q;
                    end
                    in_ready_q      <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign class_valid    = class_valid_q;
    assign class_idx      = class_idx_q;
    assign max_score      = max_score_q;
    assign confident      = confident_q;
    assign word_detected  = word_detected_q;
    assign detected_class = detected_class_q;

endmodule

// File: tb/tb_nn_argmax_detector.sv
// Bench for nn_argmax_detector (4 classes, threshold 16, agreement 3): directed
// vector table, mid-scan reset, and a continuous random stream against a model.
module tb_nn_argmax_detector;
    import nn_argmax_detector_pkg::*;

    typedef score_t [3:0] vec4_t;

    typedef struct {
        int s0, s1, s2, s3;
        int e_idx, e_max, e_conf, e_wd, e_dcls;
    } vec_t;

    typedef struct {
        int due, idx, mx, conf, wd;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    vec4_t      scores;
    logic       class_valid;
    logic [1:0] class_idx;
    score_t     max_score;
    logic       confident;
    logic       word_detected;
    logic [1:0] detected_class;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc, run, last_cls, nres;
    int   e_idx, e_max, e_conf, e_dcls;
    res_t q[$];
    vec_t tbl[18];

    nn_argmax_detector #(
        .N_CLASSES(4),
        .THRESHOLD(8'sd16),
        .AGREE_CNT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .scores(scores),
        .class_valid(class_valid),
        .class_idx(class_idx),
        .max_score(max_score),
        .confident(confident),
        .word_detected(word_detected),
        .detected_class(detected_class)
    );

    always #5 clk = ~clk;

    function automatic vec4_t mk(input int a0, input int a1, input int a2, input int a3);
        vec4_t v;
        v[0] = score_t'(a0);
        v[1] = score_t'(a1);
        v[2] = score_t'(a2);
        v[3] = score_t'(a3);
        return v;
    endfunction

    function automatic vec4_t rnd_vec();
        vec4_t v;
        int    w;
        if ($urandom_range(7, 0) == 0) begin
            for (int i = 0; i < 4; i++) v[i] = score_t'(int'($urandom_range(255, 0)) - 128);
        end else begin
            w = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : 2;
            for (int i = 0; i < 4; i++) v[i] = score_t'(int'($urandom_range(80, 0)) - 60);
            v[w] = score_t'(int'($urandom_range(40, 0)) - 10);
        end
        return v;
    endfunction

    task automatic chk(input int act, input int exp, input string name);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: arg-max with lowest-index tie break, unbounded run length of
    // confident identical decisions; a detection is exactly run length == 3.
    task automatic mon();
        res_t r;
        int   exp_rdy, exp_cv, exp_wd, b;
        if (!rst_n) begin
            chk(int'(class_valid), 0, "rst_class_valid");
            chk(int'(in_ready), 1, "rst_in_ready");
            chk(int'(class_idx), 0, "rst_class_idx");
            chk(int'(max_score), 0, "rst_max_score");
            chk(int'(confident), 0, "rst_confident");
            chk(int'(word_detected), 0, "rst_word_detected");
            chk(int'(detected_class), 0, "rst_detected_class");
            q.delete();
            run = 0; last_cls = 0; cyc = 0;
            e_idx = 0; e_max = 0; e_conf = 0; e_dcls = 0;
            return;
        end
        cyc++;
        exp_rdy = 1; exp_cv = 0; exp_wd = 0;
        if (q.size() != 0) begin
            if (q[0].due == cyc) begin
                r = q.pop_front();
                exp_cv = 1; exp_wd = r.wd;
                e_idx = r.idx; e_max = r.mx; e_conf = r.conf;
                if (r.wd != 0) e_dcls = r.idx;
                nres++;
            end else begin
                exp_rdy = 0;
            end
        end
        chk(int'(in_ready), exp_rdy, "m_in_ready");
        chk(int'(class_valid), exp_cv, "m_class_valid");
        chk(int'(word_detected), exp_wd, "m_word_detected");
        chk(int'(class_idx), e_idx, "m_class_idx");
        chk(int'(max_score), e_max, "m_max_score");
        chk(int'(confident), e_conf, "m_confident");
        chk(int'(detected_class), e_dcls, "m_detected_class");
        if (in_valid && in_ready) begin
            b = 0;
            for (int i = 1; i < 4; i++) if (int'(scores[i]) > int'(scores[b])) b = i;
            r.due  = cyc + 5;
            r.idx  = b;
            r.mx   = int'(scores[b]);
            r.conf = (r.mx >= 16) ? 1 : 0;
            if (r.conf == 0) run = 0;
            else if (run > 0 && b == last_cls) run++;
            else begin run = 1; last_cls = b; end
            r.wd = (run == 3) ? 1 : 0;
            q.push_back(r);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec4_t v, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        scores = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!class_valid && lat < 12) begin tick(); lat++; end
    endtask

    initial begin
        int lat, nres0, n;
        tbl[0]  = '{5, 40, 12, 40,     1, 40, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,        0, 0, 0, 0, 0};
        tbl[2]  = '{1, 2, 30, 3,       2, 30, 1, 0, 0};
        tbl[3]  = '{1, 2, 30, 3,       2, 30, 1, 0, 0};
        tbl[4]  = '{1, 2, 30, 3,       2, 30, 1, 1, 2};
        tbl[5]  = '{1, 2, 30, 3,       2, 30, 1, 0, 2};
        tbl[6]  = '{-5, -3, -8, -1,    3, -1, 0, 0, 2};
        tbl[7]  = '{0, 0, 30, 0,       2, 30, 1, 0, 2};
        tbl[8]  = '{0, 0, 30, 0,       2, 30, 1, 0, 2};
        tbl[9]  = '{0, 50, 30, 0,      1, 50, 1, 0, 2};
        tbl[10] = '{0, 0, 30, 0,       2, 30, 1, 0, 2};
        tbl[11] = '{0, 0, 30, 0,       2, 30, 1, 0, 2};
        tbl[12] = '{0, 0, 30, 0,       2, 30, 1, 1, 2};
        tbl[13] = '{16, 15, 0, 0,      0, 16, 1, 0, 2};
        tbl[14] = '{15, 15, 15, 15,    0, 15, 0, 0, 2};
        tbl[15] = '{-1, -2, 20, 127,   3, 127, 1, 0, 2};
        tbl[16] = '{-1, -2, 20, 127,   3, 127, 1, 0, 2};
        tbl[17] = '{-1, -2, 20, 127,   3, 127, 1, 1, 3};

        nres = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        scores = mk(0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // directed vectors: tie break, zero vector, streaks, threshold boundary
        for (int i = 0; i < 18; i++) begin
            send(mk(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3), lat);
            chk(lat, 4, $sformatf("t%0d_latency", i));
            chk(int'(class_idx), tbl[i].e_idx, $sformatf("t%0d_class_idx", i));
            chk(int'(max_score), tbl[i].e_max, $sformatf("t%0d_max_score", i));
            chk(int'(confident), tbl[i].e_conf, $sformatf("t%0d_confident", i));
            chk(int'(word_detected), tbl[i].e_wd, $sformatf("t%0d_word_detected", i));
            chk(int'(detected_class), tbl[i].e_dcls, $sformatf("t%0d_detected_class", i));
        end

        // reset asserted mid-scan: outputs clear at once, captured vector is dropped
        scores = mk(1, 2, 30, 3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk(int'(class_idx), 0, "async_rst_class_idx");
        chk(int'(max_score), 0, "async_rst_max_score");
        chk(int'(detected_class), 0, "async_rst_detected_class");
        chk(int'(in_ready), 1, "async_rst_in_ready");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();

        // continuous in_valid with scores changing every cycle
        nres0 = nres;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            scores = rnd_vec();
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin tick(); n++; end
        chk(q.size(), 0, "drain_pending");
        chk(nres - nres0, 60, "stream_results");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
